sad_bram_writer: RTL and testbench

Write-side BRAM interface for the stereo SAD path: accepts a burst request (left/right base byte addresses plus word count) and a valid/ready stream of paired left/right 32-bit pixel words, and writes them into the left and right camera BRAMs in lockstep. It sits between the capture/packing logic and the same dual BRAM ports that the SAD read interface uses. A one-cycle `bram_complete` pulse follows the last committed write.

---
 rtl/sad_bram_pkg.sv | 19 +
 rtl/sad_wr_addr_gen.sv | 63 ++++++
 rtl/sad_bram_writer.sv | 140 ++++++++++++++
 tb/tb_sad_bram_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_bram_pkg.sv
// Shared definitions for the stereo SAD BRAM read/write interfaces.
package sad_bram_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned WE_W           = 4;
    localparam int unsigned STATE_W        = 4;
    localparam int unsigned BRAM_ADDR_STEP = 4;

    localparam logic [WE_W-1:0] BRAM_WE_ALL  = 4'hF;
    localparam logic [WE_W-1:0] BRAM_WE_NONE = 4'h0;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 4'd0,
        ST_HOLD  = 4'd7,
        ST_WRITE = 4'd8
    } state_e;

endpackage

// File: rtl/sad_wr_addr_gen.sv
// Burst address generator: latches both base addresses and the word count,
// counts accepted beats and presents the current left/right byte addresses.
module sad_wr_addr_gen
    import sad_bram_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              beat,
    input  logic [ADDR_W-1:0] left_base,
    input  logic [ADDR_W-1:0] right_base,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] l_addr_c,
    output logic [ADDR_W-1:0] r_addr_c,
    output logic              last_c
);

    logic [ADDR_W-1:0] l_base_q, l_base_d;
    logic [ADDR_W-1:0] r_base_q, r_base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] offset_c;

    always_comb begin
        l_base_d = l_base_q;
        r_base_d = r_base_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        if (load) begin
            l_base_d = left_base;
            r_base_d = right_base;
            len_d    = len;
            cnt_d    = '0;
        end else if (beat) begin
            cnt_d = cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_base_q <= '0;
            r_base_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            l_base_q <= l_base_d;
            r_base_q <= r_base_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
        end
    end

    // Modular 32-bit arithmetic: bursts may wrap past the top of the address space.
    always_comb begin
        offset_c = ADDR_W'(cnt_q) * ADDR_W'(BRAM_ADDR_STEP);
        l_addr_c = l_base_q + offset_c;
        r_addr_c = r_base_q + offset_c;
        last_c   = (cnt_q == (len_q - LEN_W'(1)));
    end

endmodule

// File: rtl/sad_bram_writer.sv
// Write-side BRAM interface: streams paired left/right pixel words into the
// two camera BRAMs in lockstep and pulses bram_complete after the last write.
module sad_bram_writer
    import sad_bram_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic               axi_clk,
    input  logic               axi_rst,
    input  logic               wr_start,
    input  logic [ADDR_W-1:0]  wr_left_base,
    input  logic [ADDR_W-1:0]  wr_right_base,
    input  logic [LEN_W-1:0]   wr_len,
    input  logic [DATA_W-1:0]  l_wdata,
    input  logic [DATA_W-1:0]  r_wdata,
    input  logic               wdata_valid,
    output logic               wdata_ready,
    output logic               busy,
    output logic               bram_complete,
    output logic [STATE_W-1:0] STATE,
    output logic [ADDR_W-1:0]  l_addr_BRAM,
    output logic [ADDR_W-1:0]  r_addr_BRAM,
    output logic [DATA_W-1:0]  l_dout_BRAM,
    output logic [DATA_W-1:0]  r_dout_BRAM,
    output logic               en_BRAM,
    output logic [WE_W-1:0]    we_BRAM,
    output logic               clk_BRAM,
    output logic               rst_BRAM
);

    state_e            state_q, state_d;
    logic              en_q, en_d;
    logic [WE_W-1:0]   we_q, we_d;
    logic [ADDR_W-1:0] l_addr_q, l_addr_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [DATA_W-1:0] l_dout_q, l_dout_d;
    logic [DATA_W-1:0] r_dout_q, r_dout_d;
    logic              complete_q, complete_d;

    logic              load_c;
    logic              beat_c;
    logic [ADDR_W-1:0] gen_l_addr_c;
    logic [ADDR_W-1:0] gen_r_addr_c;
    logic              gen_last_c;

    assign load_c = (state_q == ST_IDLE) && wr_start;
    assign beat_c = (state_q == ST_WRITE) && wdata_valid;

    sad_wr_addr_gen #(
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .clk        (axi_clk),
        .rst        (axi_rst),
        .load       (load_c),
        .beat       (beat_c),
        .left_base  (wr_left_base),
        .right_base (wr_right_base),
        .len        (wr_len),
        .l_addr_c   (gen_l_addr_c),
        .r_addr_c   (gen_r_addr_c),
        .last_c     (gen_last_c)
    );

    // Next-state and registered BRAM pin values.
    always_comb begin
        state_d    = state_q;
        en_d       = 1'b0;
        we_d       = BRAM_WE_NONE;
        l_addr_d   = l_addr_q;
        r_addr_d   = r_addr_q;
        l_dout_d   = l_dout_q;
        r_dout_d   = r_dout_q;
        complete_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_start) begin
                    state_d = (wr_len == '0) ? ST_HOLD : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wdata_valid) begin
                    en_d     = 1'b1;
                    we_d     = BRAM_WE_ALL;
                    l_addr_d = gen_l_addr_c;
                    r_addr_d = gen_r_addr_c;
                    l_dout_d = l_wdata;
                    r_dout_d = r_wdata;
                    if (gen_last_c) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                l_addr_d   = '0;
                r_addr_d   = '0;
                complete_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            we_q       <= BRAM_WE_NONE;
            l_addr_q   <= '0;
            r_addr_q   <= '0;
            l_dout_q   <= '0;
            r_dout_q   <= '0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            we_q       <= we_d;
            l_addr_q   <= l_addr_d;
            r_addr_q   <= r_addr_d;
            l_dout_q   <= l_dout_d;
            r_dout_q   <= r_dout_d;
            complete_q <= complete_d;
        end
    end

    assign wdata_ready   = (state_q == ST_WRITE);
    assign busy          = (state_q != ST_IDLE);
    assign STATE         = state_q;
    assign bram_complete = complete_q;
    assign en_BRAM       = en_q;
    assign we_BRAM       = we_q;
    assign l_addr_BRAM   = l_addr_q;
    assign r_addr_BRAM   = r_addr_q;
    assign l_dout_BRAM   = l_dout_q;
    assign r_dout_BRAM   = r_dout_q;
    assign clk_BRAM      = axi_clk;
    assign rst_BRAM      = axi_rst;

endmodule

// File: tb/tb_sad_bram_writer.sv
// Self-checking bench for sad_bram_writer: burst table plus scoreboard of BRAM writes.
module tb_sad_bram_writer;

    logic        axi_clk;
    logic        axi_rst;
    logic        wr_start;
    logic [31:0] wr_left_base;
    logic [31:0] wr_right_base;
    logic [7:0]  wr_len;
    logic [31:0] l_wdata;
    logic [31:0] r_wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic        busy;
    logic        bram_complete;
    logic [3:0]  STATE;
    logic [31:0] l_addr_BRAM;
    logic [31:0] r_addr_BRAM;
    logic [31:0] l_dout_BRAM;
    logic [31:0] r_dout_BRAM;
    logic        en_BRAM;
    logic [3:0]  we_BRAM;
    logic        clk_BRAM;
    logic        rst_BRAM;

    sad_bram_writer #(.LEN_W(8)) dut (
        .axi_clk       (axi_clk),
        .axi_rst       (axi_rst),
        .wr_start      (wr_start),
        .wr_left_base  (wr_left_base),
        .wr_right_base (wr_right_base),
        .wr_len        (wr_len),
        .l_wdata       (l_wdata),
        .r_wdata       (r_wdata),
        .wdata_valid   (wdata_valid),
        .wdata_ready   (wdata_ready),
        .busy          (busy),
        .bram_complete (bram_complete),
        .STATE         (STATE),
        .l_addr_BRAM   (l_addr_BRAM),
        .r_addr_BRAM   (r_addr_BRAM),
        .l_dout_BRAM   (l_dout_BRAM),
        .r_dout_BRAM   (r_dout_BRAM),
        .en_BRAM       (en_BRAM),
        .we_BRAM       (we_BRAM),
        .clk_BRAM      (clk_BRAM),
        .rst_BRAM      (rst_BRAM)
    );

    typedef struct packed {
        logic [31:0] la;
        logic [31:0] ra;
        logic [31:0] ld;
        logic [31:0] rd;
    } wr_t;

    typedef struct {
        logic [31:0] lb;
        logic [31:0] rb;
        logic [7:0]  len;
        int          stall_after;
        int          exp_writes;
        logic [31:0] exp_last_l;
        logic [31:0] exp_last_r;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    wr_t         exp_q [$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          writes_seen = 0;
    logic [31:0] last_l = '0;
    logic [31:0] last_r = '0;
    logic        mon_on = 1'b0;

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every enabled BRAM cycle must match the next expected write.
    always @(negedge axi_clk) begin
        if (mon_on) begin
            chk("we_vs_en", 32'(we_BRAM), en_BRAM ? 32'hF : 32'h0);
            if (bram_complete === 1'b1) chk("complete_no_we", 32'(we_BRAM), 32'h0);
            if (en_BRAM === 1'b1) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h required=none t=%0t", l_addr_BRAM, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("l_addr", l_addr_BRAM, mon_e.la);
                    chk("r_addr", r_addr_BRAM, mon_e.ra);
                    chk("l_dout", l_dout_BRAM, mon_e.ld);
                    chk("r_dout", r_dout_BRAM, mon_e.rd);
                end
                last_l = l_addr_BRAM;
                last_r = r_addr_BRAM;
            end
        end
    end

    task automatic run_burst(input int v);
        vec_t t;
        int   wr0;
        t   = vecs[v];
        wr0 = writes_seen;
        @(posedge axi_clk); #1;
        chk("idle_before", 32'(STATE), 32'd0);
        wr_start      = 1'b1;
        wr_left_base  = t.lb;
        wr_right_base = t.rb;
        wr_len        = t.len;
        @(posedge axi_clk); #1;
        wr_start      = 1'b0;
        wr_left_base  = ~t.lb;
        wr_right_base = ~t.rb;
        wr_len        = 8'hFF;
        if (t.len != 8'd0) begin
            chk("busy_write", 32'(busy), 32'd1);
            for (int i = 0; i < int'(t.len); i++) begin
                if (t.stall_after >= 0 && i == t.stall_after + 1) begin
                    for (int s = 0; s < 2; s++) begin
                        wdata_valid = 1'b0;
                        l_wdata     = $urandom;
                        r_wdata     = $urandom;
                        @(posedge axi_clk); #1;
                    end
                end
                chk("ready", 32'(wdata_ready), 32'd1);
                wr_start    = (i == 1);
                wdata_valid = 1'b1;
                l_wdata     = (32'(v) << 16) | (32'hA0 + 32'(i));
                r_wdata     = (32'(v) << 16) | (32'hB0 + 32'(i));
                exp_q.push_back('{t.lb + 32'(4 * i), t.rb + 32'(4 * i), l_wdata, r_wdata});
                @(posedge axi_clk); #1;
            end
            wdata_valid = 1'b0;
            wr_start    = 1'b0;
        end
        chk("hold_state", 32'(STATE), 32'd7);
        chk("hold_no_complete", 32'(bram_complete), 32'd0);
        @(posedge axi_clk); #1;
        chk("complete_pulse", 32'(bram_complete), 32'd1);
        chk("complete_idle", 32'(STATE), 32'd0);
        chk("complete_busy", 32'(busy), 32'd0);
        chk("complete_addr", l_addr_BRAM | r_addr_BRAM, 32'd0);
        @(posedge axi_clk); #1;
        chk("complete_end", 32'(bram_complete), 32'd0);
        chk("write_count", 32'(writes_seen - wr0), 32'(t.exp_writes));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        if (t.exp_writes > 0) begin
            chk("last_l_addr", last_l, t.exp_last_l);
            chk("last_r_addr", last_r, t.exp_last_r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0000_0800, 8'd4,  -1, 4,  32'h0000_010C, 32'h0000_080C};
        vecs[1] = '{32'h0000_0100, 32'h0000_0800, 8'd4,   1, 4,  32'h0000_010C, 32'h0000_080C};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 8'd0,  -1, 0,  32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFF8, 32'h0000_0200, 8'd3,  -1, 3,  32'h0000_0000, 32'h0000_0208};
        vecs[4] = '{32'h0000_1000, 32'h0000_2000, 8'd1,  -1, 1,  32'h0000_1000, 32'h0000_2000};
        vecs[5] = '{32'h0000_0040, 32'h0000_0080, 8'd16,  7, 16, 32'h0000_007C, 32'h0000_00BC};
        vecs[6] = '{32'h0000_0500, 32'h0000_0600, 8'd1,  -1, 1,  32'h0000_0500, 32'h0000_0600};

        axi_rst       = 1'b1;
        wr_start      = 1'b0;
        wr_left_base  = '0;
        wr_right_base = '0;
        wr_len        = '0;
        l_wdata       = '0;
        r_wdata       = '0;
        wdata_valid   = 1'b0;
        @(posedge axi_clk);
        @(posedge axi_clk); #1;
        chk("rst_state", 32'(STATE), 32'd0);
        chk("rst_ready", 32'(wdata_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en_we", 32'({en_BRAM, we_BRAM}), 32'd0);
        chk("rst_complete", 32'(bram_complete), 32'd0);
        chk("rst_addr", l_addr_BRAM | r_addr_BRAM, 32'd0);
        chk("rst_dout", l_dout_BRAM | r_dout_BRAM, 32'd0);
        chk("rst_fwd", 32'(rst_BRAM), 32'd1);
        chk("clk_fwd", 32'(clk_BRAM), 32'd1);
        axi_rst = 1'b0;
        mon_on  = 1'b1;

        for (int v = 0; v < NV - 1; v++) run_burst(v);

        // Reset in the middle of a len=8 burst, after two beats.
        @(posedge axi_clk); #1;
        wr_start      = 1'b1;
        wr_left_base  = 32'h0000_0300;
        wr_right_base = 32'h0000_0900;
        wr_len        = 8'd8;
        @(posedge axi_clk); #1;
        wr_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata_valid = 1'b1;
            l_wdata     = 32'hC0 + 32'(i);
            r_wdata     = 32'hD0 + 32'(i);
            exp_q.push_back('{32'h300 + 32'(4 * i), 32'h900 + 32'(4 * i), l_wdata, r_wdata});
            @(posedge axi_clk); #1;
        end
        axi_rst     = 1'b1;
        wdata_valid = 1'b1;
        l_wdata     = 32'hC2;
        r_wdata     = 32'hD2;
        @(posedge axi_clk); #1;
        chk("mid_rst_state", 32'(STATE), 32'd0);
        chk("mid_rst_en_we", 32'({en_BRAM, we_BRAM}), 32'd0);
        chk("mid_rst_addr", l_addr_BRAM | r_addr_BRAM, 32'd0);
        chk("mid_rst_dout", l_dout_BRAM | r_dout_BRAM, 32'd0);
        chk("mid_rst_complete", 32'(bram_complete), 32'd0);
        chk("mid_rst_ready", 32'(wdata_ready), 32'd0);
        axi_rst     = 1'b0;
        wdata_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge axi_clk); #1;
            chk("post_rst_no_complete", 32'(bram_complete), 32'd0);
            chk("post_rst_idle", 32'(STATE), 32'd0);
        end
        chk("post_rst_queue", 32'(exp_q.size()), 32'd0);

        run_burst(NV - 1);

        repeat (2) @(posedge axi_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
